io_bus_arbiter: RTL and testbench



---
 rtl/io_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_io_bus_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the single I/O controller slave port between the CPU
// data port (m0) and the DMA/boot loader (m1). Round-robin grant, one slave
// transaction at a time, with a watchdog that terminates a stuck access.
module io_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [10:0] m0_address,
    input  logic [31:0] m0_data_in,
    input  logic [3:0]  m0_be,
    output logic [31:0] m0_data_out,
    output logic        m0_wait,
    output logic        m0_err,

    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [10:0] m1_address,
    input  logic [31:0] m1_data_in,
    input  logic [3:0]  m1_be,
    output logic [31:0] m1_data_out,
    output logic        m1_wait,
    output logic        m1_err,

    output logic        s_read,
    output logic        s_write,
    output logic [10:0] s_address,
    output logic [31:0] s_data_in,
    output logic [3:0]  s_be,
    input  logic [31:0] s_data_out,
    input  logic        s_wait,

    output logic [7:0]  timeout_cnt
);

    // A zero TIMEOUT disables the watchdog; keep the counter at least one bit
    // wide so the design still elaborates in that configuration.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             req0;
    logic             req1;
    logic             grant_pick;   // master chosen this cycle when in IDLE
    logic             grant;        // master owning the current transaction
    logic             last_grant;   // master served by the previous transaction
    logic             is_write;
    logic [31:0]      rdata;
    logic             err;
    logic [CNT_W-1:0] cnt;
    logic             timed_out;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // The watchdog fires on the TIMEOUT-th access cycle that still sees s_wait.
    assign timed_out = (state == ACCESS) && s_wait && (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Round-robin choice and next-state logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_next = state;
        grant_pick = (req0 && req1) ? ~last_grant : req1;
        case (state)
            IDLE:    if (req0 || req1) state_next = ACCESS;
            ACCESS:  if (!s_wait || timed_out) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // pre-edge values, independent of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Command latch, access counter, completion status and timeout statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            is_write    <= 1'b0;
            s_address   <= '0;
            s_data_in   <= '0;
            s_be        <= '0;
            rdata       <= '0;
            err         <= 1'b0;
            cnt         <= '0;
            timeout_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant <= grant_pick;
                        cnt   <= '0;
                        if (grant_pick) begin
                            is_write  <= m1_write;
                            s_address <= m1_address;
                            s_data_in <= m1_data_in;
                            s_be      <= m1_be;
                        end else begin
                            is_write  <= m0_write;
                            s_address <= m0_address;
                            s_data_in <= m0_data_in;
                            s_be      <= m0_be;
                        end
                    end
                end
                ACCESS: begin
                    if (!s_wait) begin
                        if (!is_write) rdata <= s_data_out;
                        err <= 1'b0;
                    end else if (timed_out) begin
                        rdata <= ERR_DATA;
                        err   <= 1'b1;
                        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

    // Slave strobes are only active during ACCESS; IDLE and DONE give the
    // slave a strobe-free cycle between transactions.
    assign s_read  = (state == ACCESS) && !is_write;
    assign s_write = (state == ACCESS) &&  is_write;

    // Completion is reported only to the granted master, only in DONE.
    assign m0_wait     = !((state == DONE) && !grant);
    assign m0_data_out = ((state == DONE) && !grant) ? rdata : 32'd0;
    assign m0_err      = (state == DONE) && !grant && err;

    assign m1_wait     = !((state == DONE) && grant);
    assign m1_data_out = ((state == DONE) && grant) ? rdata : 32'd0;
    assign m1_err      = (state == DONE) && grant && err;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: instance a uses TIMEOUT=4, instance b has
// the watchdog disabled. Both share the same stimulus.
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [10:0] m0_address, m1_address;
    logic [31:0] m0_data_in, m1_data_in, s_data_out;
    logic [3:0]  m0_be, m1_be;
    logic        s_wait;

    logic [31:0] a_m0_data_out, a_m1_data_out, a_s_data_in;
    logic        a_m0_wait, a_m0_err, a_m1_wait, a_m1_err, a_s_read, a_s_write;
    logic [10:0] a_s_address;
    logic [3:0]  a_s_be;
    logic [7:0]  a_timeout_cnt;

    logic [31:0] b_m0_data_out, b_m1_data_out, b_s_data_in;
    logic        b_m0_wait, b_m0_err, b_m1_wait, b_m1_err, b_s_read, b_s_write;
    logic [10:0] b_s_address;
    logic [3:0]  b_s_be;
    logic [7:0]  b_timeout_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_data_in(m0_data_in), .m0_be(m0_be), .m0_data_out(a_m0_data_out),
        .m0_wait(a_m0_wait), .m0_err(a_m0_err),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_data_in(m1_data_in), .m1_be(m1_be), .m1_data_out(a_m1_data_out),
        .m1_wait(a_m1_wait), .m1_err(a_m1_err),
        .s_read(a_s_read), .s_write(a_s_write), .s_address(a_s_address),
        .s_data_in(a_s_data_in), .s_be(a_s_be), .s_data_out(s_data_out),
        .s_wait(s_wait), .timeout_cnt(a_timeout_cnt)
    );

    io_bus_arbiter #(.TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_data_in(m0_data_in), .m0_be(m0_be), .m0_data_out(b_m0_data_out),
        .m0_wait(b_m0_wait), .m0_err(b_m0_err),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_data_in(m1_data_in), .m1_be(m1_be), .m1_data_out(b_m1_data_out),
        .m1_wait(b_m1_wait), .m1_err(b_m1_err),
        .s_read(b_s_read), .s_write(b_s_write), .s_address(b_s_address),
        .s_data_in(b_s_data_in), .s_be(b_s_be), .s_data_out(s_data_out),
        .s_wait(s_wait), .timeout_cnt(b_timeout_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_data_in = '0; m0_be = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_data_in = '0; m1_be = '0;
        s_wait = 0; s_data_out = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    // Wait (bounded) for a completion pulse to m0 on instance a.
    task automatic wait_a_m0(input string tag);
        int t = 0;
        do begin
            tick();
            t++;
        end while (a_m0_wait !== 1'b0 && t < 20);
        check(tag, a_m0_wait, 0);
    endtask

    initial begin
        int strobe_bad;
        int early_done;
        logic g;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_m0_wait", a_m0_wait, 1);
        check("rst_m1_wait", a_m1_wait, 1);
        check("rst_strobes", {a_s_read, a_s_write}, 0);
        check("rst_s_address", a_s_address, 0);
        check("rst_m0_data", a_m0_data_out, 0);
        check("rst_timeout_cnt", a_timeout_cnt, 0);

        // ---------------- single read, one slave wait cycle ----------------
        m0_read = 1; m0_address = 11'h010; s_wait = 1; s_data_out = 32'h0000_A5A5;
        tick();
        check("t1_s_read_c1", a_s_read, 1);
        check("t1_addr", a_s_address, 11'h010);
        check("t1_m0_wait_c1", a_m0_wait, 1);
        tick();
        check("t1_s_read_c2", a_s_read, 1);
        s_wait = 0;
        tick();
        check("t1_m0_wait_done", a_m0_wait, 0);
        check("t1_m0_data", a_m0_data_out, 32'h0000_A5A5);
        check("t1_m0_err", a_m0_err, 0);
        check("t1_m1_wait", a_m1_wait, 1);
        check("t1_strobe_off", a_s_read, 0);
        m0_read = 0;
        tick();
        check("t1_m0_wait_after", a_m0_wait, 1);

        // ---------------- both masters continuously: strict alternation ----------------
        do_reset();
        m0_read = 1; m0_address = 11'h000;
        m1_read = 1; m1_address = 11'h020;
        s_wait = 0; s_data_out = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            g = i[0];
            tick();
            check("t2_addr", a_s_address, g ? 11'h020 : 11'h000);
            check("t2_strobe", a_s_read, 1);
            tick();
            check("t2_m0_wait", a_m0_wait, g ? 1 : 0);
            check("t2_m1_wait", a_m1_wait, g ? 0 : 1);
            tick();
            check("t2_gap", {a_s_read, a_s_write}, 0);
        end

        // ---------------- m1 write, command changes after grant ----------------
        do_reset();
        m1_write = 1; m1_address = 11'h400; m1_data_in = 32'hCAFE_F00D; m1_be = 4'b0011;
        s_wait = 1;
        tick();
        check("t3_s_write_c1", a_s_write, 1);
        check("t3_s_read_c1", a_s_read, 0);
        check("t3_addr_c1", a_s_address, 11'h400);
        m1_address = 11'h7FF; m1_data_in = 32'h0; m1_be = 4'hF;
        tick();
        check("t3_addr_c2", a_s_address, 11'h400);
        check("t3_data_c2", a_s_data_in, 32'hCAFE_F00D);
        check("t3_be_c2", a_s_be, 4'b0011);
        check("t3_s_write_c2", a_s_write, 1);
        s_wait = 0;
        tick();
        check("t3_m1_wait", a_m1_wait, 0);
        check("t3_m1_err", a_m1_err, 0);
        check("t3_m1_data", a_m1_data_out, 0);
        check("t3_m0_wait", a_m0_wait, 1);
        clear_inputs();
        tick();

        // ---------------- timeout and counter saturation (instance a) ----------------
        do_reset();
        m0_read = 1; m0_address = 11'h055; s_wait = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_strobe", a_s_read, 1);
        end
        tick();
        check("t4_m0_wait", a_m0_wait, 0);
        check("t4_m0_data", a_m0_data_out, 32'hFFFF_FFFF);
        check("t4_m0_err", a_m0_err, 1);
        check("t4_strobe_off", a_s_read, 0);
        check("t4_timeout_cnt1", a_timeout_cnt, 1);
        for (int n = 2; n <= 300; n++) begin
            wait_a_m0("t4_repeat_done");
            if (n == 100) check("t4_timeout_cnt100", a_timeout_cnt, 100);
            if (n == 255) check("t4_timeout_cnt255", a_timeout_cnt, 255);
        end
        check("t4_timeout_sat", a_timeout_cnt, 255);
        check("t4_err_sat", a_m0_err, 1);

        // ---------------- reset in the middle of ACCESS ----------------
        m0_read = 0;
        tick();
        m0_read = 1; m0_address = 11'h010; s_wait = 1;
        tick();
        check("t5_strobe_c1", a_s_read, 1);
        tick();
        rst = 1;
        tick();
        check("t5_strobe_rst", a_s_read, 0);
        check("t5_m0_wait_rst", a_m0_wait, 1);
        check("t5_m1_wait_rst", a_m1_wait, 1);
        check("t5_timeout_rst", a_timeout_cnt, 0);
        check("t5_addr_rst", a_s_address, 0);
        rst = 0;
        m1_read = 1; m1_address = 11'h020; s_wait = 0; s_data_out = 32'h5A5A_0F0F;
        tick();
        check("t5_addr_m0_first", a_s_address, 11'h010);
        check("t5_strobe", a_s_read, 1);
        tick();
        check("t5_m0_wait", a_m0_wait, 0);
        check("t5_m1_wait", a_m1_wait, 1);
        check("t5_m0_data", a_m0_data_out, 32'h5A5A_0F0F);
        check("t5_m0_err", a_m0_err, 0);

        // ---------------- watchdog disabled (instance b) ----------------
        do_reset();
        m0_read = 1; m0_address = 11'h123; s_wait = 1; s_data_out = 32'h1234_5678;
        strobe_bad = 0;
        early_done = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (b_s_read !== 1'b1) strobe_bad++;
            if (b_m0_wait !== 1'b1) early_done++;
        end
        check("t6_strobe_held", strobe_bad, 0);
        check("t6_no_early_done", early_done, 0);
        s_wait = 0;
        tick();
        check("t6_m0_wait", b_m0_wait, 0);
        check("t6_m0_data", b_m0_data_out, 32'h1234_5678);
        check("t6_m0_err", b_m0_err, 0);
        check("t6_timeout_cnt", b_timeout_cnt, 0);
        clear_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
